// File: rtl/deemph_iir_if.sv
// FIFO-side signals of the de-emphasis stage: upstream FWFT read port
// and downstream write port, grouped so the stage sees one bundle.
interface deemph_iir_if #(
    parameter int DATA_SIZE = 32
);
    logic [DATA_SIZE-1:0] x_in_dout;
    logic                 x_in_empty;
    logic                 x_in_rd_en;
    logic [DATA_SIZE-1:0] y_out_din;
    logic                 y_out_full;
    logic                 y_out_wr_en;

    modport master (
        input  x_in_dout,
        input  x_in_empty,
        input  y_out_full,
        output x_in_rd_en,
        output y_out_din,
        output y_out_wr_en
    );

    modport slave (
        output x_in_dout,
        output x_in_empty,
        output y_out_full,
        input  x_in_rd_en,
        input  y_out_din,
        input  y_out_wr_en
    );
endinterface

// File: rtl/deemph_iir.sv
// First-order IIR de-emphasis: y = b0*x + b1*x[n-1] + a1*y[n-1],
// one sample per four cycles between two FIFOs.
module deemph_iir #(
    parameter int                   DATA_SIZE = 32,
    parameter int                   BITS      = 10,
    parameter logic [DATA_SIZE-1:0] B0        = 32'h000000B2,
    parameter logic [DATA_SIZE-1:0] B1        = 32'h000000B2,
    parameter logic [DATA_SIZE-1:0] A1        = 32'hFFFFFD66
) (
    input  logic          clock,
    input  logic          reset,
    deemph_iir_if.master  bus
);
    localparam int PW = 2 * DATA_SIZE;

    localparam logic signed [DATA_SIZE-1:0] C_B0 = B0;
    localparam logic signed [DATA_SIZE-1:0] C_B1 = B1;
    localparam logic signed [DATA_SIZE-1:0] C_A1 = A1;
    localparam logic signed [PW-1:0] RND =
        {{(PW-BITS){1'b0}}, {BITS{1'b1}}};

    typedef enum logic [1:0] {
        S_READ,
        S_MULT,
        S_SUM,
        S_WRITE
    } state_t;

    state_t state;
    state_t state_nx;

    logic signed [DATA_SIZE-1:0] x_cur;
    logic signed [DATA_SIZE-1:0] x_prev;
    logic signed [DATA_SIZE-1:0] y_prev;
    logic signed [DATA_SIZE-1:0] y_reg;
    logic signed [DATA_SIZE-1:0] y_sum;
    logic signed [PW-1:0]        p0;
    logic signed [PW-1:0]        p1;
    logic signed [PW-1:0]        p2;
    logic                        rd_en;
    logic                        wr_en;

    function automatic logic signed [PW-1:0] mul(
        input logic signed [DATA_SIZE-1:0] a,
        input logic signed [DATA_SIZE-1:0] b
    );
        return PW'(a) * PW'(b);
    endfunction

    // Signed divide by 2^BITS, rounding toward zero.
    function automatic logic signed [DATA_SIZE-1:0] dq(
        input logic signed [PW-1:0] p
    );
        logic signed [PW-1:0] r;
        r = p[PW-1] ? ((p + RND) >>> BITS) : (p >>> BITS);
        return r[DATA_SIZE-1:0];
    endfunction

    assign y_sum = dq(p0) + dq(p1) + dq(p2);

    // Strobes are held low while reset is asserted.
    assign rd_en = reset && (state == S_READ) && !bus.x_in_empty;
    assign wr_en = reset && (state == S_WRITE) && !bus.y_out_full;

    assign bus.x_in_rd_en  = rd_en;
    assign bus.y_out_wr_en = wr_en;
    assign bus.y_out_din   = y_reg;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_READ:  if (rd_en) state_nx = S_MULT;
            S_MULT:  state_nx = S_SUM;
            S_SUM:   state_nx = S_WRITE;
            S_WRITE: if (wr_en) state_nx = S_READ;
            default: state_nx = S_READ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_READ;
            x_cur  <= '0;
            x_prev <= '0;
            y_prev <= '0;
            y_reg  <= '0;
            p0     <= '0;
            p1     <= '0;
            p2     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_READ: begin
                    if (rd_en) x_cur <= bus.x_in_dout;
                end
                S_MULT: begin
                    p0 <= mul(C_B0, x_cur);
                    p1 <= mul(C_B1, x_prev);
                    p2 <= mul(C_A1, y_prev);
                end
                S_SUM: begin
                    y_reg  <= y_sum;
                    x_prev <= x_cur;
                    y_prev <= y_sum;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/deemph_iir.md
# deemph_iir

First-order IIR de-emphasis stage for the FM receiver audio path. It sits directly downstream of the L−R/L+R subtraction stage. It reads the raw right-channel samples from that stage's output FIFO and applies the 75 µs de-emphasis filter y[n] = b0·x[n] + b1·x[n−1] + a1·y[n−1] in fixed point. It writes one filtered sample per input into its own output FIFO, which feeds the gain/audio output stage.

## Interface
Parameters:
- DATA_SIZE, 32: sample and coefficient width; signed two's complement.
- BITS, 10: quantization shift; the dequantize divisor is 2^BITS.
- B0, 32'h000000B2: feed-forward coefficient for x[n] (+178).
- B1, 32'h000000B2: feed-forward coefficient for x[n−1] (+178).
- A1, 32'hFFFFFD66: feedback coefficient for y[n−1] (−666). The sign is already folded in, so this term is added.

Ports:
- clock, in, 1: single clock domain; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low. Low clears all state immediately.
- x_in_dout, in, DATA_SIZE: head of the upstream FIFO. First-word-fall-through: valid whenever x_in_empty is low.
- x_in_empty, in, 1: upstream FIFO empty.
- x_in_rd_en, out, 1: pops the upstream FIFO. Combinational from state and x_in_empty.
- y_out_din, out, DATA_SIZE: filtered sample to the downstream FIFO. Registered.
- y_out_full, in, 1: downstream FIFO full.
- y_out_wr_en, out, 1: write strobe to the downstream FIFO. Combinational from state and y_out_full.

## Operation
- Registers:
  - x_cur: current input sample.
  - x_prev: x[n−1].
  - y_prev: y[n−1].
  - p0, p1, p2: products, 2·DATA_SIZE signed.
  - y_reg: drives y_out_din.
  - 2-bit state.
- FSM states: S_READ, S_MULT, S_SUM, S_WRITE.
- S_READ:
  - x_in_rd_en = !x_in_empty.
  - When it is high, capture x_cur ← x_in_dout and go to S_MULT. Otherwise hold.
- S_MULT: p0 ← B0·x_cur, p1 ← B1·x_prev, p2 ← A1·y_prev, all full-width signed. Go to S_SUM.
- S_SUM:
  - y_reg ← dq(p0) + dq(p1) + dq(p2), truncated to DATA_SIZE (wrap, no saturation).
  - x_prev ← x_cur, y_prev ← the new y value (same edge).
  - Go to S_WRITE.
- dq(p) is signed division by 2^BITS, rounding toward zero:
  - p < 0: (p + 2^BITS − 1) >>> BITS.
  - p ≥ 0: p >>> BITS.
  - Result is truncated to DATA_SIZE.
- S_WRITE:
  - y_out_wr_en = !y_out_full.
  - When it is high, go to S_READ. Otherwise hold, with y_out_din stable.
- No input is consumed while a result is pending. Exactly one output is produced per input, in order.

## Timing
- Reset, while low:
  - state = S_READ.
  - x_cur, x_prev, y_prev, p0–p2, y_reg = 0.
  - x_in_rd_en = 0 and y_out_wr_en = 0, since the reset state forces both strobes low.
  - y_out_din = 0.
- Reset asserted mid-sample aborts the sample. The pending result is never written and the filter history is cleared.
- Latency, with no stalls:
  - x_in_rd_en is high in cycle k.
  - The product edge is at the end of k+1 and the sum edge at the end of k+2.
  - y_out_wr_en is high in cycle k+3, with y_out_din valid in that cycle.
- Throughput: at most one sample per 4 cycles. The next x_in_rd_en is at k+4 at the earliest.
- Upstream empty: the block idles in S_READ with x_in_rd_en low. There is no spurious read and all history is held.
- Downstream full: the block holds in S_WRITE with y_out_wr_en low and y_out_din unchanged. It writes in the first cycle y_out_full is low.
- Empty and full are never sampled in the same state, so the two conditions cannot interact.

## Test plan
- Impulse:
  - Stimulus: x = 1024, 0, 0, 0 after reset.
  - Required y: 178, 63, −40, 26.
  - 63 = 178 − 115 and −40 = dq(−41958). 26 = dq(666·40) = dq(26640) = 26; the positive product takes no toward-zero rounding adjustment.
- Step:
  - Stimulus: constant x = 1024.
  - Required y: 178, 241, 200 (= 356 − 156).
  - Compare the full 1000-sample run against the team C model, bit-exact.
- Rounding toward zero:
  - Stimulus: x = −1, then 0.
  - Required y: 0, 0. An arithmetic-shift-only implementation would give −1, so this scenario catches it.
- Backpressure:
  - Stimulus: y_out_full held high 10 cycles while in S_WRITE.
  - Required: y_out_wr_en = 0 and y_out_din constant; x_in_rd_en = 0 throughout.
  - Release: exactly one write, then a read on the next cycle if input is available.
- Starved input:
  - Stimulus: x_in_empty toggled randomly over 200 samples.
  - Required: output count = input count and order preserved; no read while empty; no write while full.
- Reset mid-operation:
  - Stimulus: reset low in S_SUM after 5 samples; release; feed x = 1024.
  - Required: no write of the aborted sample; first output 178, with history cleared.
